// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset execution core. It has a register file, an ALU and data memory.
// Define CPU_DBG_PORT_EN to add the dbg_addr/dbg_data register read-back port.
module cpu #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Inst,
`ifdef CPU_DBG_PORT_EN
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
`endif
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic [31:0] alu_result
);

  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [5:0]  fn;
  logic [15:0] imm;

  assign op  = Inst[31:26];
  assign rs  = Inst[25:21];
  assign rt  = Inst[20:16];
  assign rd  = Inst[15:11];
  assign sh  = Inst[10:6];
  assign fn  = Inst[5:0];
  assign imm = Inst[15:0];

  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] sext;
  logic [31:0] zext;

  assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign sext   = {{16{imm[15]}}, imm};
  assign zext   = {16'h0000, imm};

  logic [31:0] alu;
  logic        wr_en;
  logic [4:0]  dest;
  logic        is_lw;
  logic        is_sw;

  always_comb begin
    alu   = 32'd0;
    wr_en = 1'b0;
    dest  = rt;
    is_lw = 1'b0;
    is_sw = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest  = rd;
        wr_en = 1'b1;
        case (fn)
          FN_ADD:  alu = rs_val + rt_val;
          FN_SUB:  alu = rs_val - rt_val;
          FN_AND:  alu = rs_val & rt_val;
          FN_OR:   alu = rs_val | rt_val;
          FN_SLT:  alu = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
          FN_SLL:  alu = rt_val << sh;
          FN_SRL:  alu = rt_val >> sh;
          default: wr_en = 1'b0;
        endcase
      end
      OP_ADDI: begin alu = rs_val + sext; wr_en = 1'b1; end
      OP_SLTI: begin
        alu   = ($signed(rs_val) < $signed(sext)) ? 32'd1 : 32'd0;
        wr_en = 1'b1;
      end
      OP_ANDI: begin alu = rs_val & zext; wr_en = 1'b1; end
      OP_ORI:  begin alu = rs_val | zext; wr_en = 1'b1; end
      OP_LUI:  begin alu = {imm, 16'h0000}; wr_en = 1'b1; end
      OP_LW:   begin alu = rs_val + sext; wr_en = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin alu = rs_val + sext; is_sw = 1'b1; end
      default: ;
    endcase
  end

  // Word index drops the byte offset; address bits above the memory depth wrap.
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_rdata;

  assign mem_idx   = alu[AW+1:2];
  assign mem_rdata = dmem[mem_idx];

  assign alu_result  = alu;
  assign reg_wr_en   = wr_en;
  assign reg_wr_addr = dest;
  assign reg_wr_data = is_lw ? mem_rdata : alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wr_en && (dest != 5'd0)) begin
      regs[dest] <= reg_wr_data;
    end
  end

  // Data memory keeps its contents through reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (rst_n && is_sw) dmem[mem_idx] <= rt_val;
  end

`ifdef CPU_DBG_PORT_EN
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the cpu core. Register contents are read back through "or $0,$rN,$0".
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Inst = 32'hFC00_0000;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] alu_result;
`ifdef CPU_DBG_PORT_EN
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu #(.DMEM_WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Inst        (Inst),
`ifdef CPU_DBG_PORT_EN
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
`endif
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .alu_result  (alu_result)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one instruction mid-cycle; the following rising edge commits it.
  task automatic issue(input logic [31:0] i);
    @(negedge clk);
    Inst = i;
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [4:0] addr,
                           input logic [31:0] data);
    check({tag, ".en"}, {31'd0, reg_wr_en}, {31'd0, en});
    check({tag, ".addr"}, {27'd0, reg_wr_addr}, {27'd0, addr});
    check({tag, ".data"}, reg_wr_data, data);
  endtask

  task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    issue(rtype(r, 5'd0, 5'd0, 5'd0, 6'h25));
    check(tag, reg_wr_data, exp);
`ifdef CPU_DBG_PORT_EN
    dbg_addr = r;
    #1;
    check({tag, ".dbg"}, dbg_data, exp);
`endif
  endtask

  logic [31:0] fa;
  logic [31:0] fb;
  logic [31:0] fexp;

  initial begin
    // Reset held across an edge: addi must not commit.
    issue(itype(6'h08, 5'd0, 5'd3, 16'd5));
    expect_wr("rst_addi", 1'b1, 5'd3, 32'd5);
    issue(32'hFC00_0000);
    rst_n = 1'b1;
    read_reg("rst_r3", 5'd3, 32'd0);
    read_reg("rst_r1", 5'd1, 32'd0);

    // Fibonacci
    issue(itype(6'h08, 5'd0, 5'd1, 16'd1));
    expect_wr("fib_init1", 1'b1, 5'd1, 32'd1);
    issue(itype(6'h08, 5'd0, 5'd2, 16'd1));
    expect_wr("fib_init2", 1'b1, 5'd2, 32'd1);
    fa = 32'd1;
    fb = 32'd1;
    for (int k = 0; k < 10; k++) begin
      fexp = fa + fb;
      if (k % 2 == 0) begin
        issue(rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h20));
        fa = fexp;
      end else begin
        issue(rtype(5'd1, 5'd2, 5'd2, 5'd0, 6'h20));
        fb = fexp;
      end
      check($sformatf("fib_add%0d", k), reg_wr_data, fexp);
    end
    check("fib_last", reg_wr_data, 32'd144);
    read_reg("fib_r1", 5'd1, 32'd89);
    read_reg("fib_r2", 5'd2, 32'd144);

    // ALU
    issue(itype(6'h08, 5'd0, 5'd4, 16'hFFFF));
    expect_wr("addi_neg", 1'b1, 5'd4, 32'hFFFF_FFFF);
    issue(rtype(5'd4, 5'd0, 5'd5, 5'd0, 6'h2A));
    expect_wr("slt", 1'b1, 5'd5, 32'd1);
    issue(rtype(5'd0, 5'd4, 5'd6, 5'd28, 6'h02));
    expect_wr("srl", 1'b1, 5'd6, 32'h0000_000F);
    issue(itype(6'h0F, 5'd0, 5'd7, 16'h1234));
    expect_wr("lui", 1'b1, 5'd7, 32'h1234_0000);
    issue(rtype(5'd0, 5'd2, 5'd9, 5'd4, 6'h00));
    check("sll", alu_result, 32'h0000_0900);
    issue(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h22));
    check("sub", alu_result, 32'hFFFF_FFC9);
    issue(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h24));
    check("and", alu_result, 32'h0000_0010);
    issue(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h25));
    check("or", alu_result, 32'h0000_00D9);
    issue(rtype(5'd0, 5'd4, 5'd11, 5'd0, 6'h2A));
    check("slt_false", alu_result, 32'd0);
    issue(itype(6'h0A, 5'd4, 5'd12, 16'h0000));
    check("slti", alu_result, 32'd1);
    issue(itype(6'h0C, 5'd4, 5'd13, 16'h00FF));
    check("andi", alu_result, 32'h0000_00FF);
    issue(itype(6'h0D, 5'd0, 5'd14, 16'h8000));
    check("ori_zext", alu_result, 32'h0000_8000);
    issue(itype(6'h0F, 5'd0, 5'd15, 16'h7FFF));
    issue(itype(6'h0D, 5'd15, 5'd15, 16'hFFFF));
    issue(itype(6'h08, 5'd15, 5'd15, 16'd1));
    check("addi_ovf", alu_result, 32'h8000_0000);
    read_reg("r6", 5'd6, 32'h0000_000F);
    read_reg("r7", 5'd7, 32'h1234_0000);

    // Memory
    issue(itype(6'h2B, 5'd0, 5'd2, 16'd8));
    check("sw_en", {31'd0, reg_wr_en}, 32'd0);
    check("sw_addr", alu_result, 32'd8);
    issue(itype(6'h23, 5'd0, 5'd8, 16'd8));
    expect_wr("lw", 1'b1, 5'd8, 32'd144);
    issue(itype(6'h23, 5'd0, 5'd16, 16'h0108));
    check("lw_alias", reg_wr_data, 32'd144);
    issue(itype(6'h2B, 5'd0, 5'd1, 16'h0108));
    issue(itype(6'h23, 5'd0, 5'd17, 16'd8));
    check("sw_alias", reg_wr_data, 32'd89);
    issue(itype(6'h08, 5'd0, 5'd19, 16'd16));
    issue(itype(6'h23, 5'd19, 5'd20, 16'hFFF8));
    check("lw_negoff", reg_wr_data, 32'd89);
    issue(itype(6'h08, 5'd0, 5'd18, 16'd8));
    issue(itype(6'h23, 5'd18, 5'd18, 16'd0));
    check("lw_selfbase", reg_wr_data, 32'd89);
    read_reg("r8", 5'd8, 32'd144);
    read_reg("r18", 5'd18, 32'd89);

    // $0 and NOPs
    issue(itype(6'h08, 5'd0, 5'd0, 16'd7));
    expect_wr("addi_r0", 1'b1, 5'd0, 32'd7);
    read_reg("r0", 5'd0, 32'd0);
    issue(itype(6'h3F, 5'd1, 5'd1, 16'h0001));
    check("nop_op_en", {31'd0, reg_wr_en}, 32'd0);
    issue(rtype(5'd1, 5'd2, 5'd1, 5'd0, 6'h3F));
    check("nop_fn_en", {31'd0, reg_wr_en}, 32'd0);
    issue({6'h3F, 5'd0, 5'd2, 16'd8});
    read_reg("nop_r1", 5'd1, 32'd89);
    issue(itype(6'h23, 5'd0, 5'd21, 16'd8));
    check("nop_mem", reg_wr_data, 32'd89);

    // Asynchronous reset clears registers without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    Inst = rtype(5'd2, 5'd0, 5'd0, 5'd0, 6'h25);
    #1;
    check("async_rst_r2", reg_wr_data, 32'd0);
    issue(32'hFC00_0000);
    rst_n = 1'b1;
    issue(itype(6'h23, 5'd0, 5'd22, 16'd8));
    check("mem_survives_rst", reg_wr_data, 32'd89);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
